// File: rtl/flop_delay_checker.sv
// -----------------------------------------------------------------------------
// flop_delay_checker
//
// Monitor that sits beside a pipelined "flop" DUT. It keeps a ring buffer of
// recent flop_in_i values. On every edge it checks that flop_out_i equals
// flop_in_i delayed by num_clks_i cycles. It reports a registered mismatch
// pulse, saturating check/error counters, a sticky configuration error flag,
// and the first failing expected/observed pair.
//
// Optional feature macro: FLOPCHK_STOP_ON_ERR_EN
//   When defined, the first mismatch moves the FSM into HALT. HALT freezes the
//   ring buffer and all counters, and busy_o drops. Only enable_i=0 or reset
//   leaves HALT.
//   When undefined, there is no HALT state and the checker keeps counting
//   after errors.
//
// Parameters
//   WIDTH      data width of flop_in_i / flop_out_i
//   MAX_DELAY  ring depth = largest checkable num_clks_i (power of 2, >= 2)
//   CNT_W      width of err_count_o / chk_count_o
//
// Ports
//   clk_i        in   1      clock, rising edge
//   rst_n_i      in   1      asynchronous active-low reset
//   enable_i     in   1      1 = run the checker, 0 = return to IDLE
//   num_clks_i   in   32     configured DUT delay in cycles
//   flop_in_i    in   WIDTH  DUT input this cycle
//   flop_out_i   in   WIDTH  DUT output this cycle
//   mismatch_o   out  1      registered pulse: the compare at the previous edge failed
//   err_count_o  out  CNT_W  saturating mismatch count
//   chk_count_o  out  CNT_W  saturating compare count
//   cfg_err_o    out  1      sticky: num_clks_i > MAX_DELAY seen while enabled
//   first_exp_o  out  WIDTH  expected value of the first mismatch
//   first_got_o  out  WIDTH  observed value of the first mismatch
//   busy_o       out  1      FSM is in WARMUP or CHECK
// -----------------------------------------------------------------------------
module flop_delay_checker #(
    parameter int WIDTH     = 32,
    parameter int MAX_DELAY = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enable_i,
    input  logic [31:0]      num_clks_i,
    input  logic [WIDTH-1:0] flop_in_i,
    input  logic [WIDTH-1:0] flop_out_i,
    output logic             mismatch_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [CNT_W-1:0] chk_count_o,
    output logic             cfg_err_o,
    output logic [WIDTH-1:0] first_exp_o,
    output logic [WIDTH-1:0] first_got_o,
    output logic             busy_o
);

    localparam int               AW       = $clog2(MAX_DELAY);
    localparam int               FW       = AW + 1;
    localparam logic [31:0]      MAX_D32  = 32'(MAX_DELAY);
    localparam logic [FW-1:0]    MAX_FILL = FW'(MAX_DELAY);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

`ifdef FLOPCHK_STOP_ON_ERR_EN
    typedef enum logic [2:0] {S_IDLE, S_WARMUP, S_CHECK, S_CFG_ERR, S_HALT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_WARMUP, S_CHECK, S_CFG_ERR} state_t;
`endif

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [31:0]       num_q;
    logic              mismatch_q, mismatch_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [CNT_W-1:0]  chk_q, chk_d;
    logic              cfg_err_q, cfg_err_d;
    logic [WIDTH-1:0]  first_exp_q, first_exp_d;
    logic [WIDTH-1:0]  first_got_q, first_got_d;

    logic [WIDTH-1:0]  ring_q [MAX_DELAY];

    logic              running;
    logic              cfg_bad;
    logic              num_changed;
    logic [FW-1:0]     fill_base;
    logic [FW-1:0]     fill_inc;
    logic              warm_done;
    logic [AW-1:0]     rd_idx;
    logic [WIDTH-1:0]  expected;
    logic              do_write;
    logic              do_compare;
    logic              cmp_fail;

    // ------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------
    assign running     = (state_q == S_WARMUP) || (state_q == S_CHECK);
    assign cfg_bad     = (num_clks_i > MAX_D32);
    assign num_changed = (num_clks_i != num_q);

    // A delay change restarts qualification. The edge on which the change is
    // seen already writes a sample, so it counts as the first warm-up edge.
    assign fill_base = num_changed ? '0 : fill_q;
    assign fill_inc  = (fill_base == MAX_FILL) ? fill_base : fill_base + FW'(1);
    assign warm_done = (num_clks_i == 32'd0) || (32'(fill_inc) == num_clks_i);

    // The read happens before this edge's write. For a delay of MAX_DELAY, the
    // read therefore lands on the slot about to be overwritten, which holds the
    // oldest sample.
    assign rd_idx   = wr_ptr_q - num_clks_i[AW-1:0];
    assign expected = (num_clks_i == 32'd0) ? flop_in_i : ring_q[rd_idx];

    assign do_write   = enable_i && running && !cfg_bad;
    assign do_compare = enable_i && (state_q == S_CHECK) && !cfg_bad && !num_changed;
    assign cmp_fail   = do_compare && (flop_out_i != expected);

    // ------------------------------------------------------------------
    // State register (plus datapath registers)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            num_q       <= '0;
            mismatch_q  <= 1'b0;
            err_q       <= '0;
            chk_q       <= '0;
            cfg_err_q   <= 1'b0;
            first_exp_q <= '0;
            first_got_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            num_q       <= num_clks_i;
            mismatch_q  <= mismatch_d;
            err_q       <= err_d;
            chk_q       <= chk_d;
            cfg_err_q   <= cfg_err_d;
            first_exp_q <= first_exp_d;
            first_got_q <= first_got_d;
        end
    end

    // The history contents need no reset: nothing is compared until the
    // entries have been rewritten during WARMUP.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            ring_q[wr_ptr_q] <= flop_in_i;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = cfg_bad ? S_CFG_ERR : S_WARMUP;
                end
                S_WARMUP, S_CHECK: begin
                    if (cfg_bad) begin
                        state_d = S_CFG_ERR;
                    end else if ((state_q == S_WARMUP) || num_changed) begin
                        state_d = warm_done ? S_CHECK : S_WARMUP;
`ifdef FLOPCHK_STOP_ON_ERR_EN
                    end else if (cmp_fail) begin
                        state_d = S_HALT;
`endif
                    end
                end
                S_CFG_ERR: state_d = S_CFG_ERR;
`ifdef FLOPCHK_STOP_ON_ERR_EN
                S_HALT:    state_d = S_HALT;
`endif
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        chk_d       = chk_q;
        err_d       = err_q;
        mismatch_d  = cmp_fail;
        cfg_err_d   = cfg_err_q;
        first_exp_d = first_exp_q;
        first_got_d = first_got_q;

        if (do_write) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        if (state_q == S_IDLE) begin
            fill_d = '0;
        end else if (do_write && ((state_q == S_WARMUP) || num_changed)) begin
            fill_d = fill_inc;
        end

        if (do_compare && (chk_q != CNT_MAX)) begin
            chk_d = chk_q + CNT_W'(1);
        end

        if (cmp_fail) begin
            if (err_q != CNT_MAX) begin
                err_d = err_q + CNT_W'(1);
            end
            if (err_q == '0) begin
                first_exp_d = expected;
                first_got_d = flop_out_i;
            end
        end

        if (state_d == S_CFG_ERR) begin
            cfg_err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy_o = running;
    end

    assign mismatch_o  = mismatch_q;
    assign err_count_o = err_q;
    assign chk_count_o = chk_q;
    assign cfg_err_o   = cfg_err_q;
    assign first_exp_o = first_exp_q;
    assign first_got_o = first_got_q;

endmodule

// File: tb/tb_flop_delay_checker.sv
// Testbench for flop_delay_checker.
// Instance u_a uses the default parameters. Instance u_b uses CNT_W=4 to
// exercise counter saturation.
// Every expected mismatch event is queued by the stimulus. The negedge
// monitors pop and compare each mismatch pulse. The end-of-phase status is
// checked against hand-computed constants.
module tb_flop_delay_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;
    logic [31:0] num_clks = '0;
    logic [31:0] flop_in = '0;
    logic [31:0] flop_out = '0;

    logic        mm_a, cfg_a, busy_a;
    logic [15:0] err_a, chk_a;
    logic [31:0] fexp_a, fgot_a;

    logic        mm_b, cfg_b, busy_b;
    logic [3:0]  err_b, chk_b;
    logic [31:0] fexp_b, fgot_b;

    flop_delay_checker #(.WIDTH(32), .MAX_DELAY(16), .CNT_W(16)) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(en_a), .num_clks_i(num_clks),
        .flop_in_i(flop_in), .flop_out_i(flop_out), .mismatch_o(mm_a),
        .err_count_o(err_a), .chk_count_o(chk_a), .cfg_err_o(cfg_a),
        .first_exp_o(fexp_a), .first_got_o(fgot_a), .busy_o(busy_a)
    );

    flop_delay_checker #(.WIDTH(32), .MAX_DELAY(16), .CNT_W(4)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(en_b), .num_clks_i(num_clks),
        .flop_in_i(flop_in), .flop_out_i(flop_out), .mismatch_o(mm_b),
        .err_count_o(err_b), .chk_count_o(chk_b), .cfg_err_o(cfg_b),
        .first_exp_o(fexp_b), .first_got_o(fgot_b), .busy_o(busy_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          err;
        logic [31:0] exp;
        logic [31:0] got;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];

`ifdef FLOPCHK_STOP_ON_ERR_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", name, got);
        end
    endtask

    // Apply one input vector, then advance past the next rising edge.
    task automatic tick(input logic [31:0] din, input logic [31:0] dout);
        flop_in  = din;
        flop_out = dout;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dly(input int e, input int d);
        return (e >= d) ? 32'(e - d) : 32'd0;
    endfunction

    task automatic do_reset();
        en_a  = 1'b0;
        en_b  = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitors: each mismatch pulse must match a queued event.
    always @(negedge clk) begin
        ev_t ev;
        if (rst_n && (mm_a === 1'b1)) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL a_unexpected_mismatch: got pulse (err_count=%0d), expected none", err_a);
            end else begin
                ev = q_a.pop_front();
                check("a_ev_err_count", 32'(err_a), 32'(ev.err));
                check("a_ev_first_exp", fexp_a, ev.exp);
                check("a_ev_first_got", fgot_a, ev.got);
            end
        end
        if (rst_n && (mm_b === 1'b1)) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL b_unexpected_mismatch: got pulse (err_count=%0d), expected none", err_b);
            end else begin
                ev = q_b.pop_front();
                check("b_ev_err_count", 32'(err_b), 32'(ev.err));
                check("b_ev_first_exp", fexp_b, ev.exp);
                check("b_ev_first_got", fgot_b, ev.got);
            end
        end
    end

    initial begin
        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mismatch", 32'(mm_a), 32'd0);
        check("rst_err_count", 32'(err_a), 32'd0);
        check("rst_chk_count", 32'(chk_a), 32'd0);
        check("rst_cfg_err", 32'(cfg_a), 32'd0);
        check("rst_first_exp", fexp_a, 32'd0);
        check("rst_first_got", fgot_a, 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        rst_n = 1'b1;

        // 1: delay 3, correct DUT. The IDLE edge is followed by 3 warm-up edges.
        num_clks = 32'd3;
        en_a = 1'b1;
        for (int e = 0; e <= 100; e++) begin
            tick(32'(e), dly(e, 3));
            if (e == 0) check("t1_busy_after_start", 32'(busy_a), 32'd1);
            if (e == 3) check("t1_chk_end_warmup", 32'(chk_a), 32'd0);
            if (e == 4) check("t1_chk_first", 32'(chk_a), 32'd1);
        end
        en_a = 1'b0;
        tick(32'd0, 32'd0);
        check("t1_chk_count", 32'(chk_a), 32'd97);
        check("t1_err_count", 32'(err_a), 32'd0);
        check("t1_busy_idle", 32'(busy_a), 32'd0);

        // 2: delay 0, output tied to input.
        do_reset();
        num_clks = 32'd0;
        en_a = 1'b1;
        for (int e = 0; e <= 11; e++) tick(32'(e + 200), 32'(e + 200));
        en_a = 1'b0;
        tick(32'd0, 32'd0);
        check("t2_chk_count", 32'(chk_a), 32'd10);
        check("t2_err_count", 32'(err_a), 32'd0);

        // 3: delay 2, one corrupted output where 5 is expected.
        do_reset();
        num_clks = 32'd2;
        en_a = 1'b1;
        for (int e = 0; e <= 20; e++) begin
            if (e == 7) begin
                q_a.push_back('{err: 1, exp: 32'h0000_0005, got: 32'hDEAD_BEEF});
                tick(32'(e), 32'hDEAD_BEEF);
            end else begin
                tick(32'(e), dly(e, 2));
            end
            if (e == 8) check("t3_pulse_ended", 32'(mm_a), 32'd0);
        end
        check("t3_busy", 32'(busy_a), HALT_EN ? 32'd0 : 32'd1);
        en_a = 1'b0;
        tick(32'd0, 32'd0);
        check("t3_err_count", 32'(err_a), 32'd1);
        check("t3_first_exp", fexp_a, 32'h0000_0005);
        check("t3_first_got", fgot_a, 32'hDEAD_BEEF);
        check("t3_chk_count", 32'(chk_a), HALT_EN ? 32'd5 : 32'd18);
        check("t3_queue_drained", 32'(q_a.size()), 32'd0);

        // 4: delay beyond MAX_DELAY, then an asynchronous reset clears it.
        do_reset();
        num_clks = 32'd17;
        en_a = 1'b1;
        for (int e = 0; e < 5; e++) tick(32'(e), dly(e, 1));
        check("t4_cfg_err", 32'(cfg_a), 32'd1);
        check("t4_chk_count", 32'(chk_a), 32'd0);
        check("t4_busy", 32'(busy_a), 32'd0);
        en_a  = 1'b0;
        rst_n = 1'b0;
        #2;
        check("t4_async_clear", 32'(cfg_a), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 4b: delay exactly MAX_DELAY is legal.
        num_clks = 32'd16;
        en_a = 1'b1;
        for (int e = 0; e <= 40; e++) tick(32'(e * 3), 32'(dly(e, 16) * 3));
        en_a = 1'b0;
        tick(32'd0, 32'd0);
        check("t4b_chk_count", 32'(chk_a), 32'd24);
        check("t4b_err_count", 32'(err_a), 32'd0);
        check("t4b_cfg_err", 32'(cfg_a), 32'd0);

        // 5: change the delay from 4 to 6 mid-run.
        do_reset();
        num_clks = 32'd4;
        en_a = 1'b1;
        for (int e = 0; e <= 10; e++) tick(32'(e), dly(e, 4));
        check("t5_chk_before", 32'(chk_a), 32'd6);
        num_clks = 32'd6;
        for (int e = 11; e <= 16; e++) tick(32'(e), dly(e, 6));
        check("t5_chk_requalify", 32'(chk_a), 32'd6);
        tick(32'd17, dly(17, 6));
        check("t5_chk_resume", 32'(chk_a), 32'd7);
        for (int e = 18; e <= 25; e++) tick(32'(e), dly(e, 6));
        check("t5_chk_final", 32'(chk_a), 32'd15);
        check("t5_err_count", 32'(err_a), 32'd0);
        en_a = 1'b0;
        tick(32'd0, 32'd0);

        // 6: CNT_W=4 instance, 20 failing compares at delay 1.
        do_reset();
        num_clks = 32'd1;
        en_b = 1'b1;
        for (int e = 0; e <= 21; e++) begin
            if (e >= 2) begin
                if (!HALT_EN || (e == 2)) begin
                    q_b.push_back('{err: ((e - 1) > 15) ? 15 : (e - 1),
                                    exp: 32'h0000_0001, got: 32'hFFFF_0001});
                end
            end
            tick(32'(e), dly(e, 1) ^ 32'hFFFF_0000);
        end
        check("t6_err_count", 32'(err_b), HALT_EN ? 32'd1 : 32'd15);
        check("t6_chk_count", 32'(chk_b), HALT_EN ? 32'd1 : 32'd15);
        check("t6_busy", 32'(busy_b), HALT_EN ? 32'd0 : 32'd1);
        check("t6_a_untouched", 32'(chk_a), 32'd0);
        en_b = 1'b0;
        tick(32'd0, 32'd0);
        check("t6_err_hold", 32'(err_b), HALT_EN ? 32'd1 : 32'd15);
        en_b = 1'b1;
        tick(32'd0, 32'd0);
        check("t6_restart_busy", 32'(busy_b), 32'd1);
        en_b = 1'b0;
        tick(32'd0, 32'd0);
        check("t6_queue_drained", 32'(q_b.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
